// File: rtl/spu_pipe_pkg.sv
// Shared definitions for the SPU result-staging pipeline.
//   REG_AW       register address width
//   DATA_W       result / register data width
//   UNIT_*       execution-unit codes (perm, load/store, branch)
//   pipe_entry_t one staging slot: {valid, write, unit, addr, ready, data}
package spu_pipe_pkg;
  localparam int REG_AW = 7;
  localparam int DATA_W = 128;
  localparam int UNIT_W = 2;

  localparam logic [UNIT_W-1:0] UNIT_PERM = 2'd0;
  localparam logic [UNIT_W-1:0] UNIT_LS   = 2'd1;
  localparam logic [UNIT_W-1:0] UNIT_BR   = 2'd2;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [UNIT_W-1:0] unit;
    logic [REG_AW-1:0] addr;
    logic              ready;
    logic [DATA_W-1:0] data;
  } pipe_entry_t;
endpackage

// File: rtl/spu_hazard_check.sv
// Per-read-port hazard check against every staging slot.
// Build option: SPU_RESULT_FWD_EN enables forwarding of ready results;
// without it any match stalls and nothing is forwarded.
// Ports:
//   rd_valid, rd_addr  source operand of this read port
//   ent_live           slot valid & write (only these can match)
//   ent_addr/ready/data slot contents, index 0 = stage 1 (youngest)
//   match              operand matches at least one live slot
//   stall              operand must wait
//   fwd_hit, fwd_data  forwarded value from the youngest matching slot
module spu_hazard_check
  import spu_pipe_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic                         rd_valid,
  input  logic [REG_AW-1:0]            rd_addr,
  input  logic [DEPTH-1:0]             ent_live,
  input  logic [DEPTH-1:0][REG_AW-1:0] ent_addr,
  input  logic [DEPTH-1:0]             ent_ready,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  output logic                         match,
  output logic                         stall,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data
);

  logic [DEPTH-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = rd_valid & ent_live[i] & (ent_addr[i] == rd_addr);
    end
  end

  assign match = |hit_vec;

`ifdef SPU_RESULT_FWD_EN
  // Walk oldest to youngest so the youngest match wins; a not-ready
  // youngest match suppresses forwarding of any older ready value.
  always_comb begin
    stall    = |(hit_vec & ~ent_ready);
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        fwd_hit  = ent_ready[i];
        fwd_data = ent_ready[i] ? ent_data[i] : '0;
      end
    end
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ent_ready, ent_data};
  assign stall    = match;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: rtl/spu_result_pipe.sv
// SPU result-staging pipeline: issued instructions travel DEPTH stages,
// capture their unit's result at that unit's delivery stage, and write
// back from the last stage. Source operands are checked for RAW hazards
// against every in-flight entry.
// Build option: SPU_RESULT_FWD_EN enables forwarding of ready results.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   issue_valid/unit/write/addr    instruction issued this cycle
//   kill                           drop stage 1 and the current issue
//   res_valid, res_data            per-unit result strobe and value
//   rd_valid, rd_addr              source-operand read ports
//   stall                          RAW stall for the current issue
//   fwd_hit, fwd_data              forwarded operand per read port
//   wb_valid, wb_addr, wb_data     register-file writeback
//   err                            sticky result-protocol error
module spu_result_pipe
  import spu_pipe_pkg::*;
#(
  parameter int DEPTH                 = 7,
  parameter int NUM_UNITS             = 3,
  parameter int UNIT_STAGE[NUM_UNITS] = '{4, 6, 1},
  parameter int NUM_RD                = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  issue_valid,
  input  logic [$clog2(NUM_UNITS)-1:0]          issue_unit,
  input  logic                                  issue_write,
  input  logic [REG_AW-1:0]                     issue_addr,
  input  logic                                  kill,
  input  logic [NUM_UNITS-1:0]                  res_valid,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]      res_data,
  input  logic [NUM_RD-1:0]                     rd_valid,
  input  logic [NUM_RD-1:0][REG_AW-1:0]         rd_addr,
  output logic                                  stall,
  output logic [NUM_RD-1:0]                     fwd_hit,
  output logic [NUM_RD-1:0][DATA_W-1:0]         fwd_data,
  output logic                                  wb_valid,
  output logic [REG_AW-1:0]                     wb_addr,
  output logic [DATA_W-1:0]                     wb_data,
  output logic                                  err
);

  pipe_entry_t stage_q [1:DEPTH];
  pipe_entry_t stage_d [1:DEPTH];
  logic        err_q, err_d;
  logic        accept;

  // Flattened view of the stages for the per-port checkers.
  logic [DEPTH-1:0]             ent_live;
  logic [DEPTH-1:0]             ent_ready;
  logic [DEPTH-1:0][REG_AW-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  logic [NUM_RD-1:0]             unused_port_match;
  logic [NUM_RD-1:0]             port_stall;
  logic [NUM_RD-1:0]             port_hit;
  logic [NUM_RD-1:0][DATA_W-1:0] port_data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_live[i]  = stage_q[i+1].valid & stage_q[i+1].write;
      ent_ready[i] = stage_q[i+1].ready;
      ent_addr[i]  = stage_q[i+1].addr;
      ent_data[i]  = stage_q[i+1].data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    spu_hazard_check #(
      .DEPTH(DEPTH)
    ) u_hazard (
      .rd_valid (rd_valid[p]),
      .rd_addr  (rd_addr[p]),
      .ent_live (ent_live),
      .ent_addr (ent_addr),
      .ent_ready(ent_ready),
      .ent_data (ent_data),
      .match    (unused_port_match[p]),
      .stall    (port_stall[p]),
      .fwd_hit  (port_hit[p]),
      .fwd_data (port_data[p])
    );
  end

  // Hazard outputs are quiet while reset is held, since stage contents
  // are stale until the first reset edge has cleared them.
  always_comb begin
    stall   = ~reset & (|port_stall);
    fwd_hit = port_hit & {NUM_RD{~reset}};
    for (int p = 0; p < NUM_RD; p++) begin
      fwd_data[p] = fwd_hit[p] ? port_data[p] : '0;
    end
  end

  assign accept = issue_valid & ~stall & ~kill;

  always_comb begin
    // New entry into stage 1; rejected issues enter as an empty slot.
    stage_d[1]       = '0;
    stage_d[1].valid = accept;
    stage_d[1].write = issue_write;
    stage_d[1].unit  = UNIT_W'(issue_unit);
    stage_d[1].addr  = issue_addr;

    // Shift; kill removes the stage-1 entry before it moves on.
    for (int i = 2; i <= DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (kill) begin
      stage_d[2].valid = 1'b0;
    end

    // Result capture as an entry lands in its unit's delivery stage.
    // A strobe without a capturing entry, or a capturing entry without a
    // strobe, is a protocol error.
    err_d = err_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (stage_d[UNIT_STAGE[u]].valid &&
          stage_d[UNIT_STAGE[u]].unit == UNIT_W'(u)) begin
        if (res_valid[u]) begin
          stage_d[UNIT_STAGE[u]].ready = 1'b1;
          stage_d[UNIT_STAGE[u]].data  = res_data[u];
        end else begin
          err_d = 1'b1;
        end
      end else if (res_valid[u]) begin
        err_d = 1'b1;
      end
    end

    if (reset) begin
      for (int i = 1; i <= DEPTH; i++) begin
        stage_d[i].valid = 1'b0;
      end
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    err_q   <= err_d;
  end

  assign wb_valid = ~reset & stage_q[DEPTH].valid & stage_q[DEPTH].write;
  assign wb_addr  = wb_valid ? stage_q[DEPTH].addr : '0;
  assign wb_data  = wb_valid ? stage_q[DEPTH].data : '0;
  assign err      = err_q;

endmodule

// File: tb/tb_spu_result_pipe.sv
module tb_spu_result_pipe;
  import spu_pipe_pkg::*;

`ifdef SPU_RESULT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   issue_valid;
  logic [1:0]             issue_unit;
  logic                   issue_write;
  logic [6:0]             issue_addr;
  logic                   kill;
  logic [2:0]             res_valid;
  logic [2:0][127:0]      res_data;
  logic [2:0]             rd_valid;
  logic [2:0][6:0]        rd_addr;
  logic                   stall;
  logic [2:0]             fwd_hit;
  logic [2:0][127:0]      fwd_data;
  logic                   wb_valid;
  logic [6:0]             wb_addr;
  logic [127:0]           wb_data;
  logic                   err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] D_AA = {16{8'hAA}};
  localparam logic [127:0] D_LS = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D_P4 = 128'h0000_0000_0000_0000_0000_0000_0000_0444;
  localparam logic [127:0] D_L4 = 128'hCAFE_0000_0000_0000_0000_0000_0000_4444;

  always #5 clk = ~clk;

  spu_result_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_unit (issue_unit),
    .issue_write(issue_write),
    .issue_addr (issue_addr),
    .kill       (kill),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .stall      (stall),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_unit  = '0;
    issue_write = 1'b0;
    issue_addr  = '0;
    kill        = 1'b0;
    res_valid   = '0;
    res_data    = '0;
    rd_valid    = '0;
    rd_addr     = '0;
  endtask

  task automatic do_issue(input logic [1:0] u, input logic w, input logic [6:0] a);
    issue_valid = 1'b1;
    issue_unit  = u;
    issue_write = w;
    issue_addr  = a;
  endtask

  task automatic do_res(input int u, input logic [127:0] d);
    res_valid[u] = 1'b1;
    res_data[u]  = d;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    rd_valid = 3'b001;
    rd_addr[0] = 7'd5;
    tick();
    tick();
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_hit", fwd_hit, 3'b000);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_wba", wb_addr, 7'd0);
    chk("rst_wbd", wb_data, 128'd0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    idle();
    tick();

    // Perm to r5, result at stage 4, writeback 7 cycles after issue.
    do_issue(UNIT_PERM, 1'b1, 7'd5);
    #1;
    chk("t1_stall0", stall, 1'b0);
    tick();
    idle();
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) do_res(0, D_AA);
      #1;
      chk($sformatf("t1_wbv_c%0d", c), wb_valid, c == 7);
      if (c == 7) begin
        chk("t1_wba", wb_addr, 7'd5);
        chk("t1_wbd", wb_data, D_AA);
      end
      tick();
      idle();
    end
    chk("t1_err", err, 1'b0);

    // LS to r9, read r9 every cycle; a stalled perm issue to r30 is dropped.
    do_issue(UNIT_LS, 1'b1, 7'd9);
    tick();
    idle();
    for (int c = 1; c <= 9; c++) begin
      rd_valid   = 3'b001;
      rd_addr[0] = 7'd9;
      if (c == 2) do_issue(UNIT_PERM, 1'b1, 7'd30);
      if (c == 5) do_res(1, D_LS);
      #1;
      chk($sformatf("t2_stall_c%0d", c), stall, FWD ? (c <= 5) : (c <= 7));
      chk($sformatf("t2_hit_c%0d", c), fwd_hit, (FWD && (c == 6 || c == 7)) ? 3'b001 : 3'b000);
      chk($sformatf("t2_fwd_c%0d", c), fwd_data[0], (FWD && (c == 6 || c == 7)) ? D_LS : 128'd0);
      chk($sformatf("t2_wbv_c%0d", c), wb_valid, c == 7);
      if (c == 7) begin
        chk("t2_wba", wb_addr, 7'd9);
        chk("t2_wbd", wb_data, D_LS);
      end
      tick();
      idle();
    end
    chk("t2_err", err, 1'b0);

    // Perm r3 (data 1), br-write r3 (data 2) next cycle; youngest wins.
    do_issue(UNIT_PERM, 1'b1, 7'd3);
    tick();
    idle();
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) begin
        do_issue(UNIT_BR, 1'b1, 7'd3);
        do_res(2, 128'd2);
      end
      if (c == 3) do_res(0, 128'd1);
      if (c == 4) begin
        rd_valid   = 3'b010;
        rd_addr[1] = 7'd3;
      end
      #1;
      if (c == 4) begin
        chk("t3_stall", stall, !FWD);
        chk("t3_hit", fwd_hit, FWD ? 3'b010 : 3'b000);
        chk("t3_fwd", fwd_data[1], FWD ? 128'd2 : 128'd0);
      end
      chk($sformatf("t3_wbv_c%0d", c), wb_valid, c == 7 || c == 8);
      if (c == 7) chk("t3_wbd7", wb_data, 128'd1);
      if (c == 8) chk("t3_wbd8", wb_data, 128'd2);
      tick();
      idle();
    end
    chk("t3_err", err, 1'b0);

    // Older ready perm r4 shadowed by a younger not-ready LS r4.
    do_issue(UNIT_PERM, 1'b1, 7'd4);
    tick();
    idle();
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) do_issue(UNIT_LS, 1'b1, 7'd4);
      if (c == 3) do_res(0, D_P4);
      if (c == 7) do_res(1, D_L4);
      if (c == 5 || c == 8) begin
        rd_valid   = 3'b100;
        rd_addr[2] = 7'd4;
      end
      #1;
      if (c == 5) begin
        chk("t4_stall5", stall, 1'b1);
        chk("t4_hit5", fwd_hit, 3'b000);
      end
      if (c == 8) begin
        chk("t4_stall8", stall, !FWD);
        chk("t4_fwd8", fwd_data[2], FWD ? D_L4 : 128'd0);
      end
      chk($sformatf("t4_wbv_c%0d", c), wb_valid, c == 7 || c == 9);
      if (c == 7) chk("t4_wbd7", wb_data, D_P4);
      if (c == 9) chk("t4_wbd9", wb_data, D_L4);
      tick();
      idle();
    end
    chk("t4_err", err, 1'b0);

    // Issue r7, kill next cycle together with an issue to r8.
    do_issue(UNIT_PERM, 1'b1, 7'd7);
    tick();
    idle();
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) begin
        kill = 1'b1;
        do_issue(UNIT_PERM, 1'b1, 7'd8);
      end
      #1;
      chk($sformatf("t5_wbv_c%0d", c), wb_valid, 1'b0);
      tick();
      idle();
    end
    chk("t5_err", err, 1'b0);

    // Branch without write: captures its result, never matches or writes.
    do_issue(UNIT_BR, 1'b0, 7'd20);
    do_res(2, 128'd5);
    tick();
    idle();
    for (int c = 1; c <= 8; c++) begin
      rd_valid   = 3'b001;
      rd_addr[0] = 7'd20;
      #1;
      chk($sformatf("t6_stall_c%0d", c), stall, 1'b0);
      chk($sformatf("t6_wbv_c%0d", c), wb_valid, 1'b0);
      tick();
      idle();
    end
    chk("t6_err", err, 1'b0);

    // Four LS entries in flight, then reset.
    for (int c = 0; c <= 3; c++) begin
      do_issue(UNIT_LS, 1'b1, 7'(10 + c));
      tick();
      idle();
    end
    rd_valid = 3'b111;
    rd_addr  = {7'd12, 7'd11, 7'd10};
    #1;
    chk("t7_stall_pre", stall, 1'b1);
    reset = 1'b1;
    #1;
    chk("t7_stall_rst", stall, 1'b0);
    tick();
    reset = 1'b0;
    for (int c = 5; c <= 12; c++) begin
      rd_valid = 3'b111;
      rd_addr  = {7'd12, 7'd11, 7'd10};
      #1;
      chk($sformatf("t7_stall_c%0d", c), stall, 1'b0);
      chk($sformatf("t7_wbv_c%0d", c), wb_valid, 1'b0);
      tick();
      idle();
    end
    chk("t7_err", err, 1'b0);

    // Stray LS strobe with no capturing entry: sticky error until reset.
    do_res(1, 128'd9);
    #1;
    chk("t8_err_pre", err, 1'b0);
    tick();
    idle();
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("t8_err_c%0d", c), err, 1'b1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t8_err_clr", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
